// File: rtl/pipeline_flow_ctrl_pkg.sv
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared state type and default widths for the pipeline flow
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } flow_state_t;

  localparam int REG_AW_DEFAULT       = 4;
  localparam int PC_W_DEFAULT         = 32;
  localparam int DRAIN_CYCLES_DEFAULT = 3;

endpackage

`default_nettype wire

// File: rtl/pipeline_flow_ctrl_if.sv
// ============================================================================
// Module      : pipeline_flow_ctrl_if
// Description : Hazard inputs and stall/flush/PC-select outputs between the
//               pipeline datapath (master) and the flow controller (slave).
//               PERF_CNT_EN adds the performance-counter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_flow_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int PC_W   = PC_W_DEFAULT
);

  logic              start;
  logic              HaltD;
  logic              BranchTakenE;
  logic [PC_W-1:0]   BranchTargetE;
  logic [REG_AW-1:0] RA1D;
  logic [REG_AW-1:0] RA2D;
  logic [REG_AW-1:0] WA3E;
  logic              MemtoRegE;

  logic              PCSelF;
  logic [PC_W-1:0]   PCTargetF;
  logic              StallF;
  logic              StallD;
  logic              FlushD;
  logic              FlushE;
  logic              Running;
  logic              Done;

`ifdef PERF_CNT_EN
  logic [31:0]       CycleCnt;
  logic [31:0]       BubbleCnt;
  logic [31:0]       BranchCnt;
`endif

  modport master (
`ifdef PERF_CNT_EN
    input  CycleCnt, BubbleCnt, BranchCnt,
`endif
    output start, HaltD, BranchTakenE, BranchTargetE, RA1D, RA2D, WA3E, MemtoRegE,
    input  PCSelF, PCTargetF, StallF, StallD, FlushD, FlushE, Running, Done
  );

  modport slave (
`ifdef PERF_CNT_EN
    output CycleCnt, BubbleCnt, BranchCnt,
`endif
    input  start, HaltD, BranchTakenE, BranchTargetE, RA1D, RA2D, WA3E, MemtoRegE,
    output PCSelF, PCTargetF, StallF, StallD, FlushD, FlushE, Running, Done
  );

endinterface

`default_nettype wire

// File: rtl/pipeline_flow_ctrl_hazard_detect.sv
// ============================================================================
// Module      : hazard_detect
// Description : Load-use compare between the load in E and the sources in D.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect #(
  parameter int REG_AW = 4
) (
  input  wire logic              MemtoRegE,
  input  wire logic [REG_AW-1:0] WA3E,
  input  wire logic [REG_AW-1:0] RA1D,
  input  wire logic [REG_AW-1:0] RA2D,
  output logic                   lwStall
);

  assign lwStall = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));

endmodule

`default_nettype wire

// File: rtl/pipeline_flow_ctrl.sv
// ============================================================================
// Module      : pipeline_flow_ctrl
// Description : Run/halt sequencer and hazard resolver for the 5-stage
//               pipeline front end. Optional macro PERF_CNT_EN adds cycle,
//               bubble and branch counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_flow_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW       = REG_AW_DEFAULT,
  parameter int PC_W         = PC_W_DEFAULT,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input wire logic            clk,
  input wire logic            reset,
  pipeline_flow_ctrl_if.slave bus
);

  localparam int               CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  flow_state_t      state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;

  logic             lw_stall;
  logic             pc_sel;
  logic [PC_W-1:0]  pc_target;
  logic             stall_f, stall_d, flush_d, flush_e;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .MemtoRegE (bus.MemtoRegE),
    .WA3E      (bus.WA3E),
    .RA1D      (bus.RA1D),
    .RA2D      (bus.RA2D),
    .lwStall   (lw_stall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pc_sel      = 1'b0;
    pc_target   = '0;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
        if (bus.start) begin
          state_d = RUN;
        end
      end

      RUN: begin
        // A taken branch flushes the D instruction, so neither a load-use
        // stall nor a halt sitting in D can take effect that cycle.
        if (bus.BranchTakenE) begin
          pc_sel    = 1'b1;
          pc_target = bus.BranchTargetE;
          flush_d   = 1'b1;
          flush_e   = 1'b1;
        end else begin
          if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
          if (bus.HaltD) begin
            stall_f     = 1'b1;
            flush_d     = 1'b1;
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end
        end
      end

      DRAIN: begin
        stall_f = 1'b1;
        flush_d = 1'b1;
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d     = DONE;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d     = IDLE;
        drain_cnt_d = '0;
      end
    endcase
  end

  assign bus.PCSelF    = pc_sel;
  assign bus.PCTargetF = pc_target;
  assign bus.StallF    = stall_f;
  assign bus.StallD    = stall_d;
  assign bus.FlushD    = flush_d;
  assign bus.FlushE    = flush_e;
  assign bus.Running   = (state_q == RUN);
  assign bus.Done      = (state_q == DONE);

`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] branch_cnt_q, branch_cnt_d;

  always_comb begin
    cycle_cnt_d  = cycle_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    branch_cnt_d = branch_cnt_q;
    if ((state_q == IDLE || state_q == DONE) && bus.start) begin
      cycle_cnt_d  = '0;
      bubble_cnt_d = '0;
      branch_cnt_d = '0;
    end
    if (state_q == RUN || state_q == DRAIN) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
    if (state_q == RUN && bus.BranchTakenE) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (state_q == RUN && !bus.BranchTakenE && lw_stall) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      branch_cnt_q <= '0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  assign bus.CycleCnt  = cycle_cnt_q;
  assign bus.BubbleCnt = bubble_cnt_q;
  assign bus.BranchCnt = branch_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_flow_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_flow_ctrl
// Description : Self-checking bench for pipeline_flow_ctrl (vector table,
//               directed corner cases, randomized run against a model).
//               PERF_CNT_EN also checks the performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_flow_ctrl;

  localparam int AW = 4;
  localparam int PW = 32;
  localparam int DC = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipeline_flow_ctrl_if #(.REG_AW(AW), .PC_W(PW)) bus ();

  pipeline_flow_ctrl #(
    .REG_AW       (AW),
    .PC_W         (PW),
    .DRAIN_CYCLES (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic          start, halt, br;
    logic [PW-1:0] tgt;
    logic [AW-1:0] ra1, ra2, wa3;
    logic          mem;
    logic          psel;
    logic [PW-1:0] ptgt;
    logic          sf, sd, fd, fe, run, done;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic psel, input logic [PW-1:0] ptgt,
                            input logic sf, input logic sd, input logic fd, input logic fe,
                            input logic run, input logic done);
    chk({tag, " PCSelF"},    {31'd0, bus.PCSelF},  {31'd0, psel});
    chk({tag, " PCTargetF"}, bus.PCTargetF,        ptgt);
    chk({tag, " StallF"},    {31'd0, bus.StallF},  {31'd0, sf});
    chk({tag, " StallD"},    {31'd0, bus.StallD},  {31'd0, sd});
    chk({tag, " FlushD"},    {31'd0, bus.FlushD},  {31'd0, fd});
    chk({tag, " FlushE"},    {31'd0, bus.FlushE},  {31'd0, fe});
    chk({tag, " Running"},   {31'd0, bus.Running}, {31'd0, run});
    chk({tag, " Done"},      {31'd0, bus.Done},    {31'd0, done});
  endtask

  task automatic drive(input logic st, input logic halt, input logic br, input logic [PW-1:0] tgt,
                       input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                       input logic [AW-1:0] wa3, input logic mem);
    bus.start         = st;
    bus.HaltD         = halt;
    bus.BranchTakenE  = br;
    bus.BranchTargetE = tgt;
    bus.RA1D          = ra1;
    bus.RA2D          = ra2;
    bus.WA3E          = wa3;
    bus.MemtoRegE     = mem;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, '0, 4'd1, 4'd2, 4'd3, 1'b0);
  endtask

  task automatic apply_row(input int i);
    @(negedge clk);
    drive(tbl[i].start, tbl[i].halt, tbl[i].br, tbl[i].tgt,
          tbl[i].ra1, tbl[i].ra2, tbl[i].wa3, tbl[i].mem);
    #1;
    check_outs($sformatf("row%0d", i), tbl[i].psel, tbl[i].ptgt, tbl[i].sf, tbl[i].sd,
               tbl[i].fd, tbl[i].fe, tbl[i].run, tbl[i].done);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Reference model: mode 0..3 = idle/run/drain/done, drain tracked as cycles left.
  int m_mode;
  int m_left;
`ifdef PERF_CNT_EN
  logic [31:0] m_cyc, m_bub, m_brn;
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              start  halt   br     tgt          ra1   ra2   wa3   mem    psel   ptgt         sf     sd     fd     fe     run    done
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,       4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,       4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,       4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,       4'd0, 4'd5, 4'd5, 1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,       4'd6, 4'd6, 4'd5, 1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h40,      4'd1, 4'd2, 4'd3, 1'b0, 1'b1, 32'h40,      1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h80,      4'd7, 4'd0, 4'd7, 1'b1, 1'b1, 32'h80,      1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h100,     4'd1, 4'd2, 4'd3, 1'b0, 1'b1, 32'h100,     1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,       4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h44,      4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,       4'd4, 4'd2, 4'd4, 1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0,       4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 32'h48,      4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,       4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,       4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_outs("reset", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Held idle with no start, then the scripted vector table
    for (int k = 0; k < 10; k++) apply_row(0);
    for (int i = 0; i < 15; i++) apply_row(i);

    // Reset asserted during the second drain cycle aborts to IDLE
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, '0, 4'd1, 4'd2, 4'd3, 1'b0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("drain1 Running", {31'd0, bus.Running}, 32'd0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_outs("abort", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    #1;
    chk("restart pre Running", {31'd0, bus.Running}, 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("restart Running", {31'd0, bus.Running}, 32'd1);
    chk("restart StallF", {31'd0, bus.StallF}, 32'd0);

    // Drain length after the abort must be the full DRAIN_CYCLES
    @(negedge clk);
    bus.HaltD = 1'b1;
    @(negedge clk);
    bus.HaltD = 1'b0;
    begin
      int n;
      n = 0;
      #1;
      while (bus.Done !== 1'b1 && n < 10) begin
        n++;
        @(negedge clk);
        #1;
      end
      chk("drain length", n, DC);
    end

`ifdef PERF_CNT_EN
    // 20-cycle program: 2 load-use stalls, 3 taken branches, then halt
    do_reset();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("perf clear CycleCnt", bus.CycleCnt, 32'd0);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, (i == 4 || i == 12 || i == 17), 32'h200,
            4'd9, 4'd8, (i == 2 || i == 9) ? 4'd8 : 4'd3, (i == 2 || i == 9));
    end
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, '0, 4'd1, 4'd2, 4'd3, 1'b0);
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    chk("perf Done", {31'd0, bus.Done}, 32'd1);
    chk("perf BubbleCnt", bus.BubbleCnt, 32'd2);
    chk("perf BranchCnt", bus.BranchCnt, 32'd3);
    chk("perf CycleCnt", bus.CycleCnt, 32'd24);
`endif

    // Randomized run against the reference model
    do_reset();
    m_mode = 0;
    m_left = 0;
`ifdef PERF_CNT_EN
    m_cyc = '0; m_bub = '0; m_brn = '0;
`endif
    for (int c = 0; c < 500; c++) begin
      logic st, halt, br, mem, lu;
      logic [PW-1:0] tgt;
      logic [AW-1:0] ra1, ra2, wa3;
      logic e_psel, e_sf, e_sd, e_fd, e_fe;
      logic [PW-1:0] e_tgt;
      st   = ($urandom_range(0, 4) == 0);
      halt = ($urandom_range(0, 15) == 0);
      br   = ($urandom_range(0, 3) == 0);
      mem  = ($urandom_range(0, 2) == 0);
      tgt  = $urandom;
      ra1  = AW'($urandom_range(0, 3));
      ra2  = AW'($urandom_range(0, 3));
      wa3  = AW'($urandom_range(0, 3));
      @(negedge clk);
      drive(st, halt, br, tgt, ra1, ra2, wa3, mem);
      #1;
      lu = mem && (wa3 == ra1 || wa3 == ra2);
      e_psel = 1'b0; e_tgt = '0; e_sf = 1'b0; e_sd = 1'b0; e_fd = 1'b0; e_fe = 1'b0;
      if (m_mode == 0 || m_mode == 3) begin
        e_sf = 1'b1; e_sd = 1'b1; e_fe = 1'b1;
      end else if (m_mode == 2) begin
        e_sf = 1'b1; e_fd = 1'b1;
      end else if (br) begin
        e_psel = 1'b1; e_tgt = tgt; e_fd = 1'b1; e_fe = 1'b1;
      end else begin
        e_sf = lu | halt; e_sd = lu; e_fe = lu; e_fd = halt;
      end
      check_outs($sformatf("rand%0d", c), e_psel, e_tgt, e_sf, e_sd, e_fd, e_fe,
                 (m_mode == 1), (m_mode == 3));
`ifdef PERF_CNT_EN
      chk($sformatf("rand%0d CycleCnt", c),  bus.CycleCnt,  m_cyc);
      chk($sformatf("rand%0d BubbleCnt", c), bus.BubbleCnt, m_bub);
      chk($sformatf("rand%0d BranchCnt", c), bus.BranchCnt, m_brn);
`endif
      case (m_mode)
        0, 3: if (st) begin
          m_mode = 1;
`ifdef PERF_CNT_EN
          m_cyc = '0; m_bub = '0; m_brn = '0;
`endif
        end
        1: begin
`ifdef PERF_CNT_EN
          m_cyc++;
          if (br) m_brn++;
          else if (lu) m_bub++;
`endif
          if (!br && halt) begin
            m_mode = 2;
            m_left = DC;
          end
        end
        default: begin
`ifdef PERF_CNT_EN
          m_cyc++;
`endif
          m_left--;
          if (m_left == 0) m_mode = 3;
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
